// File: rtl/rd_ctrl_fwft_if.sv
// Read-side FIFO controller bus: user read handshake, pointer exchange with the
// write side and the dual-port RAM read port.
interface rd_ctrl_fwft_if #(parameter int AWIDTH = 4);
    logic              rd_req_i;
    logic [AWIDTH:0]   wr_pntr_gray_i;
    logic [AWIDTH:0]   rd_pntr_gray_o;
    logic [AWIDTH-1:0] mem_rd_addr_o;
    logic              mem_rd_en_o;
    logic              rd_valid_o;
    logic              rd_empty_o;
    logic              rd_almost_empty_o;
    logic [AWIDTH:0]   rd_usedw_o;
    logic              rd_underflow_o;

    modport slave (
        input  rd_req_i, wr_pntr_gray_i,
        output rd_pntr_gray_o, mem_rd_addr_o, mem_rd_en_o, rd_valid_o,
               rd_empty_o, rd_almost_empty_o, rd_usedw_o, rd_underflow_o
    );

    modport master (
        output rd_req_i, wr_pntr_gray_i,
        input  rd_pntr_gray_o, mem_rd_addr_o, mem_rd_en_o, rd_valid_o,
               rd_empty_o, rd_almost_empty_o, rd_usedw_o, rd_underflow_o
    );
endinterface

// File: rtl/rd_ctrl_fwft.sv
// Dual-clock FIFO read controller: built-in write-pointer synchroniser, full-width
// occupancy, almost-empty/underflow flags, normal or show-ahead (FWFT) read mode.
module rd_ctrl_fwft #(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SHOWAHEAD   = 0,
    parameter int AEMPTY_LVL  = 2
) (
    input  logic          rd_clk_i,
    input  logic          aclr_i,
    rd_ctrl_fwft_if.slave bus
);
    localparam int PW = AWIDTH + 1;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {S_EMPTY, S_VALID} state_t;
    localparam ptr_t AE_LVL = ptr_t'(AEMPTY_LVL);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    ptr_t   rd_bin, rd_gray, usedw_q;
    state_t state, state_next;
    logic   empty_q, aempty_q, valid_q, under_q;

    ptr_t   wr_gray_s, wr_bin_s, rd_bin_next, mem_cnt_next, usedw_next;
    logic   avail, rd_en, empty_next;

    assign wr_gray_s = sync_q[SYNC_STAGES-1];
    assign wr_bin_s  = gray2bin(wr_gray_s);
    assign avail     = (wr_bin_s != rd_bin);

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        if (SHOWAHEAD == 0) begin
            rd_en = bus.rd_req_i & ~empty_q;
        end else begin
            // Presented word is consumed on rd_req_i; refetch in the same cycle so
            // back-to-back acknowledges see no bubble.
            case (state)
                S_EMPTY: if (avail) begin
                    rd_en      = 1'b1;
                    state_next = S_VALID;
                end
                S_VALID: if (bus.rd_req_i) begin
                    if (avail) rd_en = 1'b1;
                    else       state_next = S_EMPTY;
                end
                default: state_next = S_EMPTY;
            endcase
        end
        rd_bin_next  = rd_bin + ptr_t'(rd_en);
        mem_cnt_next = wr_bin_s - rd_bin_next;
        if (SHOWAHEAD == 0) begin
            empty_next = (bin2gray(rd_bin_next) == wr_gray_s);
            usedw_next = mem_cnt_next;
        end else begin
            empty_next = (state_next != S_VALID);
            usedw_next = mem_cnt_next + ptr_t'(state_next == S_VALID);
        end
    end

    always_ff @(posedge rd_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            sync_q   <= '0;
            rd_bin   <= '0;
            rd_gray  <= '0;
            state    <= S_EMPTY;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            usedw_q  <= '0;
            valid_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.wr_pntr_gray_i};
            rd_bin   <= rd_bin_next;
            rd_gray  <= bin2gray(rd_bin_next);
            state    <= state_next;
            empty_q  <= empty_next;
            aempty_q <= (usedw_next <= AE_LVL);
            usedw_q  <= usedw_next;
            valid_q  <= rd_en;
            under_q  <= bus.rd_req_i & empty_q;
        end
    end

    assign bus.rd_pntr_gray_o    = rd_gray;
    assign bus.mem_rd_addr_o     = rd_bin[AWIDTH-1:0];
    assign bus.mem_rd_en_o       = rd_en;
    assign bus.rd_valid_o        = (SHOWAHEAD != 0) ? ~empty_q : valid_q;
    assign bus.rd_empty_o        = empty_q;
    assign bus.rd_almost_empty_o = aempty_q;
    assign bus.rd_usedw_o        = usedw_q;
    assign bus.rd_underflow_o    = under_q;
endmodule

// File: tb/tb_rd_ctrl_fwft.sv
// Bench for rd_ctrl_fwft: one normal-mode and one FWFT instance share a write-side
// model and RAM; read data is checked against per-instance scoreboards.
module tb_rd_ctrl_fwft;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic aclr = 1'b0;
    always #5 clk = ~clk;

    rd_ctrl_fwft_if #(.AWIDTH(AW)) if0 ();
    rd_ctrl_fwft_if #(.AWIDTH(AW)) if1 ();

    rd_ctrl_fwft #(.AWIDTH(AW), .SYNC_STAGES(2), .SHOWAHEAD(0), .AEMPTY_LVL(2)) dut_n (
        .rd_clk_i(clk), .aclr_i(aclr), .bus(if0));
    rd_ctrl_fwft #(.AWIDTH(AW), .SYNC_STAGES(2), .SHOWAHEAD(1), .AEMPTY_LVL(2)) dut_f (
        .rd_clk_i(clk), .aclr_i(aclr), .bus(if1));

    logic [7:0]  mem [DEPTH];
    logic [7:0]  q0, q1;
    logic [AW:0] wr_bin;
    logic [7:0]  sb0 [$];
    logic [7:0]  sb1 [$];
    bit          mon0, mon1;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic       req, en;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       valid, empty;
        logic [4:0] usedw;
        logic       ae, un;
    } vec_t;
    vec_t tbl [8];

    // Dual-port RAM model, registered output that holds while enable is low
    always @(posedge clk) begin
        if (if0.mem_rd_en_o) q0 <= mem[if0.mem_rd_addr_o];
        if (if1.mem_rd_en_o) q1 <= mem[if1.mem_rd_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [7:0] act, input bit fwft);
        logic [7:0] e;
        if ((fwft ? sb1.size() : sb0.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d with no word expected", name, act);
        end else begin
            e = fwft ? sb1.pop_front() : sb0.pop_front();
            chk(name, act, e);
        end
    endtask

    // Scoreboard monitor: normal mode compares on rd_valid_o, FWFT on acknowledge
    always @(negedge clk) begin
        #2;
        if (aclr && mon0 && if0.rd_valid_o)                    pop_chk("data_normal", q0, 1'b0);
        if (aclr && mon1 && if1.rd_req_i && !if1.rd_empty_o)   pop_chk("data_fwft", q1, 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_word(input logic [7:0] d);
        @(negedge clk);
        mem[wr_bin[AW-1:0]] = d;
        wr_bin = wr_bin + 1'b1;
        if0.wr_pntr_gray_i = wr_bin ^ (wr_bin >> 1);
        if1.wr_pntr_gray_i = wr_bin ^ (wr_bin >> 1);
        sb0.push_back(d);
        sb1.push_back(d);
    endtask

    task automatic do_reset();
        aclr = 1'b0;
        mon0 = 1'b0;
        mon1 = 1'b0;
        if0.rd_req_i = 1'b0;
        if1.rd_req_i = 1'b0;
        wr_bin = '0;
        if0.wr_pntr_gray_i = '0;
        if1.wr_pntr_gray_i = '0;
        sb0.delete();
        sb1.delete();
        cyc(2);
        aclr = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty_n"},  if0.rd_empty_o, 1);
        chk({tag, "_aempty_n"}, if0.rd_almost_empty_o, 1);
        chk({tag, "_usedw_n"},  if0.rd_usedw_o, 0);
        chk({tag, "_valid_n"},  if0.rd_valid_o, 0);
        chk({tag, "_under_n"},  if0.rd_underflow_o, 0);
        chk({tag, "_en_n"},     if0.mem_rd_en_o, 0);
        chk({tag, "_gray_n"},   if0.rd_pntr_gray_o, 0);
        chk({tag, "_empty_f"},  if1.rd_empty_o, 1);
        chk({tag, "_aempty_f"}, if1.rd_almost_empty_o, 1);
        chk({tag, "_usedw_f"},  if1.rd_usedw_o, 0);
        chk({tag, "_valid_f"},  if1.rd_valid_o, 0);
        chk({tag, "_under_f"},  if1.rd_underflow_o, 0);
        chk({tag, "_en_f"},     if1.mem_rd_en_o, 0);
        chk({tag, "_gray_f"},   if1.rd_pntr_gray_o, 0);
    endtask

    initial begin
        // req en addr gray valid empty usedw ae un  (normal mode, 3 words stored)
        tbl[0] = '{1'b1, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd1, 5'd1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'd2, 5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 4'd3, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};

        do_reset();
        @(negedge clk); #1;
        chk_reset("init");

        // Reset mid-burst: FWFT with 5 words, 2 acknowledged
        mon1 = 1'b1;
        for (int i = 0; i < 5; i++) wr_word(8'h10 + 8'(i));
        cyc(4);
        @(negedge clk); if1.rd_req_i = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("burst_usedw_f", if1.rd_usedw_o, 3);
        #2 aclr = 1'b0;
        #1 chk_reset("midburst");

        // Normal mode: 3 words, rd_req_i held, then underflow
        do_reset();
        mon0 = 1'b1;
        for (int i = 0; i < 3; i++) wr_word(8'h20 + 8'(i));
        cyc(4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if0.rd_req_i = tbl[i].req;
            #1;
            chk($sformatf("n%0d_en", i),    if0.mem_rd_en_o, tbl[i].en);
            chk($sformatf("n%0d_addr", i),  if0.mem_rd_addr_o, tbl[i].addr);
            chk($sformatf("n%0d_gray", i),  if0.rd_pntr_gray_o, tbl[i].gray);
            chk($sformatf("n%0d_valid", i), if0.rd_valid_o, tbl[i].valid);
            chk($sformatf("n%0d_empty", i), if0.rd_empty_o, tbl[i].empty);
            chk($sformatf("n%0d_usedw", i), if0.rd_usedw_o, tbl[i].usedw);
            chk($sformatf("n%0d_aempty", i), if0.rd_almost_empty_o, tbl[i].ae);
            chk($sformatf("n%0d_under", i), if0.rd_underflow_o, tbl[i].un);
        end
        chk("n_drained", sb0.size(), 0);

        // FWFT single word: empty falls after SYNC_STAGES+1 edges, word shown ahead
        do_reset();
        mon1 = 1'b1;
        wr_word(8'hA5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("lat%0d_empty_f", k), if1.rd_empty_o, (k < 3));
            chk($sformatf("lat%0d_empty_n", k), if0.rd_empty_o, (k < 3));
        end
        chk("sa_word", q1, 8'hA5);
        chk("sa_usedw_f", if1.rd_usedw_o, 1);
        chk("sa_valid_f", if1.rd_valid_o, 1);
        chk("sa_usedw_n", if0.rd_usedw_o, 1);
        chk("sa_valid_n", if0.rd_valid_o, 0);
        @(negedge clk); if1.rd_req_i = 1'b1; #1;
        chk("sa_ack_en", if1.mem_rd_en_o, 0);
        @(negedge clk); #1;
        chk("sa_after_empty", if1.rd_empty_o, 1);
        chk("sa_after_usedw", if1.rd_usedw_o, 0);
        chk("sa_after_under", if1.rd_underflow_o, 0);
        chk("sa_uf_en", if1.mem_rd_en_o, 0);
        @(negedge clk); #1;
        chk("sa_uf_pulse", if1.rd_underflow_o, 1);
        chk("sa_uf_addr", if1.mem_rd_addr_o, 1);
        chk("sa_uf_gray", if1.rd_pntr_gray_o, 1);
        if1.rd_req_i = 1'b0;
        @(negedge clk); #1;
        chk("sa_uf_clear", if1.rd_underflow_o, 0);
        chk("sa_drained", sb1.size(), 0);

        // Full RAM plus presented word: usedw reaches DEPTH+1, drain without bubble
        do_reset();
        mon1 = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr_word(8'h40 + 8'(i));
        cyc(4);
        wr_word(8'h7F);
        cyc(4); #1;
        chk("full_usedw", if1.rd_usedw_o, DEPTH + 1);
        chk("full_empty", if1.rd_empty_o, 0);
        chk("full_aempty", if1.rd_almost_empty_o, 0);
        for (int k = 0; k <= DEPTH; k++) begin
            @(negedge clk); if1.rd_req_i = 1'b1; #1;
            chk($sformatf("drain%0d_empty", k), if1.rd_empty_o, 0);
            chk($sformatf("drain%0d_usedw", k), if1.rd_usedw_o, DEPTH + 1 - k);
            chk($sformatf("drain%0d_en", k), if1.mem_rd_en_o, (k < DEPTH));
        end
        @(negedge clk); if1.rd_req_i = 1'b0; #1;
        chk("drain_end_empty", if1.rd_empty_o, 1);
        chk("drain_end_usedw", if1.rd_usedw_o, 0);
        chk("drain_end_aempty", if1.rd_almost_empty_o, 1);
        chk("drain_sb", sb1.size(), 0);

        // Wrap: 40 words in batches of 10, both modes, pointer passes 31->0
        do_reset();
        mon0 = 1'b1;
        mon1 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) wr_word(8'(8'h80 + b * 10 + i));
            cyc(4);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if0.rd_req_i = 1'b1;
                if1.rd_req_i = 1'b1;
                #1;
                chk($sformatf("w%0d_%0d_usedw_n", b, k), if0.rd_usedw_o, 10 - k);
                chk($sformatf("w%0d_%0d_usedw_f", b, k), if1.rd_usedw_o, 10 - k);
                chk($sformatf("w%0d_%0d_ae_n", b, k), if0.rd_almost_empty_o, (10 - k) <= 2);
                chk($sformatf("w%0d_%0d_ae_f", b, k), if1.rd_almost_empty_o, (10 - k) <= 2);
            end
            @(negedge clk);
            if0.rd_req_i = 1'b0;
            if1.rd_req_i = 1'b0;
            #1;
            chk($sformatf("w%0d_empty_n", b), if0.rd_empty_o, 1);
            chk($sformatf("w%0d_empty_f", b), if1.rd_empty_o, 1);
            chk($sformatf("w%0d_usedw_f", b), if1.rd_usedw_o, 0);
        end
        @(negedge clk); #1;
        chk("wrap_gray_n", if0.rd_pntr_gray_o, 5'd12);
        chk("wrap_gray_f", if1.rd_pntr_gray_o, 5'd12);
        chk("wrap_sb_n", sb0.size(), 0);
        chk("wrap_sb_f", sb1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
